// File: rtl/gray_step_counter.sv
// Registered up/down counter that exposes its binary count as reflected Gray code.
// Optional terminal-count pulse output tc is enabled by defining GRAY_CNT_TC_EN.
module gray_step_counter #(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_cnt
`ifdef GRAY_CNT_TC_EN
  ,
  output logic             tc
`endif
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             at_max, at_zero;

  assign at_max  = (bin_q == MAXV);
  assign at_zero = (bin_q == '0);

  always_comb begin
    bin_d = bin_q;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up_dn) begin
        if (WRAP || !at_max) bin_d = bin_q + ONE;
      end else begin
        if (WRAP || !at_zero) bin_d = bin_q - ONE;
      end
    end
    // Encode the next state so the Gray register flips a single bit per step
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign bin_cnt  = bin_q;
  assign gray_out = gray_q;

`ifdef GRAY_CNT_TC_EN
  logic cross_d;
  logic tc_q;

  // A boundary crossing counts whether it wraps or is blocked by saturation
  assign cross_d = !load && en && (up_dn ? at_max : at_zero);

  always_ff @(posedge clk) begin
    if (rst) tc_q <= 1'b0;
    else     tc_q <= cross_d;
  end

  assign tc = tc_q;
`endif

endmodule

// File: tb/tb_gray_step_counter.sv
// Directed-vector bench: a wrapping (WRAP=1) and a saturating (WRAP=0) counter driven in lockstep.
module tb_gray_step_counter;

  localparam int W = 8;

  logic         clk;
  logic         rst, en, up_dn, load;
  logic [W-1:0] load_val;
  logic [W-1:0] gray_a, bin_a, gray_b, bin_b;
  logic         tc_a, tc_b;
  int           total, bad;
  logic [W-1:0] prev_gray_a, prev_gray_b, prev_exp_a, prev_exp_b;

  gray_step_counter #(.WIDTH(W), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .gray_out(gray_a), .bin_cnt(bin_a)
`ifdef GRAY_CNT_TC_EN
    , .tc(tc_a)
`endif
  );

  gray_step_counter #(.WIDTH(W), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .gray_out(gray_b), .bin_cnt(bin_b)
`ifdef GRAY_CNT_TC_EN
    , .tc(tc_b)
`endif
  );

`ifndef GRAY_CNT_TC_EN
  assign tc_a = 1'b0;
  assign tc_b = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Apply one cycle of inputs, then check both counters against hand-computed values
  task automatic vec(input string tag, input logic r, input logic ld, input logic e,
                     input logic u, input logic [W-1:0] lv,
                     input logic [W-1:0] a_bin, input logic [W-1:0] a_gray, input logic a_tc,
                     input logic [W-1:0] b_bin, input logic [W-1:0] b_gray, input logic b_tc);
    rst = r; load = ld; en = e; up_dn = u; load_val = lv;
    prev_gray_a = gray_a;
    prev_gray_b = gray_b;
    @(posedge clk);
    @(negedge clk);
    $display("%-12s rst=%0b ld=%0b en=%0b up=%0b lv=%h | A bin=%h gray=%h tc=%0b | B bin=%h gray=%h tc=%0b",
             tag, r, ld, e, u, lv, bin_a, gray_a, tc_a, bin_b, gray_b, tc_b);
    check_eq({tag, ".a_bin"},  16'(bin_a),  16'(a_bin));
    check_eq({tag, ".a_gray"}, 16'(gray_a), 16'(a_gray));
    check_eq({tag, ".b_bin"},  16'(bin_b),  16'(b_bin));
    check_eq({tag, ".b_gray"}, 16'(gray_b), 16'(b_gray));
`ifdef GRAY_CNT_TC_EN
    check_eq({tag, ".a_tc"}, 16'(tc_a), 16'(a_tc));
    check_eq({tag, ".b_tc"}, 16'(tc_b), 16'(b_tc));
`endif
    // Any count step that moves the value must flip exactly one Gray bit
    if (!r && !ld && e) begin
      if (a_bin != prev_exp_a)
        check_eq({tag, ".a_1bit"}, 16'($countones(gray_a ^ prev_gray_a)), 16'd1);
      if (b_bin != prev_exp_b)
        check_eq({tag, ".b_1bit"}, 16'($countones(gray_b ^ prev_gray_b)), 16'd1);
    end
    prev_exp_a = a_bin;
    prev_exp_b = b_bin;
  endtask

  initial begin
    total = 0; bad = 0;
    prev_exp_a = '0; prev_exp_b = '0;
    rst = 1'b1; load = 1'b0; en = 1'b0; up_dn = 1'b0; load_val = '0;

    //        tag           rst ld en up lv      A: bin   gray  tc   B: bin   gray  tc
    vec("reset0",       1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    vec("reset1",       1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 5; i++)
      vec("hold",       0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);

    vec("up1",          0, 0, 1, 1, 8'h00, 8'h01, 8'h01, 0, 8'h01, 8'h01, 0);
    vec("up2",          0, 0, 1, 1, 8'h00, 8'h02, 8'h03, 0, 8'h02, 8'h03, 0);
    vec("up3",          0, 0, 1, 1, 8'h00, 8'h03, 8'h02, 0, 8'h03, 8'h02, 0);
    vec("up4",          0, 0, 1, 1, 8'h00, 8'h04, 8'h06, 0, 8'h04, 8'h06, 0);
    vec("up5",          0, 0, 1, 1, 8'h00, 8'h05, 8'h07, 0, 8'h05, 8'h07, 0);
    vec("up6",          0, 0, 1, 1, 8'h00, 8'h06, 8'h05, 0, 8'h06, 8'h05, 0);

    vec("load_ff",      0, 1, 0, 1, 8'hFF, 8'hFF, 8'h80, 0, 8'hFF, 8'h80, 0);
    vec("wrap_up",      0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 1, 8'hFF, 8'h80, 1);
    vec("after_wrap1",  0, 0, 1, 1, 8'h00, 8'h01, 8'h01, 0, 8'hFF, 8'h80, 1);
    vec("after_wrap2",  0, 0, 1, 1, 8'h00, 8'h02, 8'h03, 0, 8'hFF, 8'h80, 1);
    vec("hold_tc0",     0, 0, 0, 1, 8'h00, 8'h02, 8'h03, 0, 8'hFF, 8'h80, 0);

    vec("reset2",       1, 0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    vec("wrap_dn",      0, 0, 1, 0, 8'h00, 8'hFF, 8'h80, 1, 8'h00, 8'h00, 1);
    vec("dn_fe",        0, 0, 1, 0, 8'h00, 8'hFE, 8'h81, 0, 8'h00, 8'h00, 1);

    vec("load_over_en", 0, 1, 1, 1, 8'h2A, 8'h2A, 8'h3F, 0, 8'h2A, 8'h3F, 0);
    vec("hold_2a",      0, 0, 0, 0, 8'h00, 8'h2A, 8'h3F, 0, 8'h2A, 8'h3F, 0);
    vec("rst_over_ld",  1, 1, 1, 1, 8'h55, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);

    vec("up_a",         0, 0, 1, 1, 8'h00, 8'h01, 8'h01, 0, 8'h01, 8'h01, 0);
    vec("up_b",         0, 0, 1, 1, 8'h00, 8'h02, 8'h03, 0, 8'h02, 8'h03, 0);
    vec("rst_mid",      1, 0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    vec("resume",       0, 0, 1, 1, 8'h00, 8'h01, 8'h01, 0, 8'h01, 8'h01, 0);
    vec("dn_to0",       0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    vec("load_at0_dn",  0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    vec("load_80",      0, 1, 0, 0, 8'h80, 8'h80, 8'hC0, 0, 8'h80, 8'hC0, 0);
    vec("dn_7f",        0, 0, 1, 0, 8'h00, 8'h7F, 8'h40, 0, 8'h7F, 8'h40, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_step_counter.md
Name: gray_step_counter

Overview:
- Registered N-bit up/down counter that presents its count as reflected binary Gray code.
- Sits directly upstream of the Gray-to-binary converter and drives its Gray input bus.
- The output register changes exactly one bit per count step, so the Gray bus can cross to slow or asynchronous consumers without multi-bit glitches.
- Internal state is held in binary; Gray encoding (g = b ^ (b >> 1)) is computed on the next-state value and registered.

Parameters:
- WIDTH, 8, counter and output width in bits (legal range 2..16).
- WRAP, 1, 1 = modulo-2^WIDTH wrap-around at both ends; 0 = saturate at 0 and at 2^WIDTH-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count-step request; one step per cycle while high.
- up_dn  input  1  direction, sampled with en: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  binary value to load.
- gray_out  output  WIDTH  registered Gray-coded count.
- bin_cnt  output  WIDTH  registered binary count, for debug/visibility; always consistent with gray_out.

Behaviour:
- Reset: on a clk edge with rst=1, bin_cnt=0 and gray_out=0 (tc=0 if the optional feature is present). rst overrides load and en.
- Priority per edge: rst > load > en > hold.
- Load: bin_cnt <= load_val and gray_out <= load_val ^ (load_val >> 1) on the same edge. Visible the cycle after load is sampled. en is ignored that cycle.
- Count: en=1, load=0.
  - up_dn=1: bin_next = bin_cnt + 1.
  - up_dn=0: bin_next = bin_cnt - 1.
  - Arithmetic is WIDTH bits; the carry/borrow is discarded.
  - Latency is 1 cycle from en to gray_out.
- Hold: en=0, load=0, rst=0 leaves both registers unchanged.
- WRAP=1 boundaries:
  - Max with up: 2^WIDTH-1 -> 0; Gray goes 1000..0 -> 0000..0.
  - Zero with down: 0 -> 2^WIDTH-1; Gray goes 0 -> 1000..0.
- WRAP=0 boundaries: up at max, or down at 0, holds the value. This is not an error; no register changes.
- Invariant: each count step changes exactly one bit of gray_out. A load may change any number of bits.
- gray_out == bin_cnt ^ (bin_cnt >> 1) holds on every cycle after the first reset.
- State before the first reset is undefined; consumers must not sample gray_out until rst has been applied.
- Reset asserted mid-count returns both outputs to 0 on that edge. Counting resumes from 0 the first edge after rst drops with en=1.
- en and up_dn are level signals with no handshake; a held en counts once per cycle indefinitely.

Optional Feature:
- Macro: GRAY_CNT_TC_EN.
- With the macro defined:
  - Adds output tc (1 bit, registered).
  - tc pulses high for exactly one cycle, coincident with gray_out, when a count step crosses the boundary: up from 2^WIDTH-1 or down from 0.
  - This applies to the wrap in WRAP=1 and to the blocked attempt in WRAP=0.
  - tc is never raised by load or reset; reset clears tc to 0.
- Without the macro: the tc port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset with WIDTH=8, WRAP=1: hold rst=1 for 2 cycles -> gray_out=8'h00, bin_cnt=8'h00. Hold en=0 for 5 cycles -> unchanged.
- Count up with en=1, up_dn=1 for 6 cycles -> gray_out sequence 00,01,03,02,06,07,05 (one per cycle, 1-cycle latency). Check single-bit change each step.
- Wrap up: load=1, load_val=8'hFF -> gray_out=8'h80. Then en=1, up_dn=1 -> gray_out=8'h00, tc=1 for one cycle (with GRAY_CNT_TC_EN).
- Wrap down from 0: en=1, up_dn=0 -> gray_out=8'h80, bin_cnt=8'hFF. Next step -> gray_out=8'h81, bin_cnt=8'hFE.
- Saturate with WRAP=0: at bin_cnt=8'hFF apply en=1, up_dn=1 for 3 cycles -> gray_out stays 8'h80, tc pulses each blocked cycle. At 0, down -> stays 8'h00.
- Priority: load=1, en=1, load_val=8'h2A on the same edge -> bin_cnt=8'h2A, gray_out=8'h3F. Then rst=1 together with load=1 -> both outputs 0.
